// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: register tags, data words and the scoreboard mask helper.
// Optional feature macro used by this slice: FORWARDING_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package operand_fetch_pkg;

  typedef logic [4:0]            tag;
  typedef logic [`WORD_SIZE-1:0] word;

  localparam int unsigned num_regs = 32;

  // One-hot mask for a register tag; x0 never has a scoreboard bit.
  function automatic logic [num_regs-1:0] tag_mask(input tag t);
    logic [num_regs-1:0] m;
    m = '0;
    if (t != '0) m[t] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/operand_fetch_bypass.sv
// Per-operand priority mux: x0 reads as zero, then ex > mem > wb > register file.
// The parent drives ex/mem valids low when FORWARDING_EN is not defined.
module operand_bypass
  import operand_fetch_pkg::*;
(
  input  tag   src,
  input  word  rf_value,
  input  logic ex_valid,
  input  tag   ex_rd,
  input  word  ex_value,
  input  logic mem_valid,
  input  tag   mem_rd,
  input  word  mem_value,
  input  logic wb_valid,
  input  tag   wb_rd,
  input  word  wb_value,
  output word  value
);

  always_comb begin
    value = rf_value;
    if (src == '0)
      value = '0;
    else if (ex_valid && (ex_rd == src))
      value = ex_value;
    else if (mem_valid && (mem_rd == src))
      value = mem_value;
    else if (wb_valid && (wb_rd == src))
      value = wb_value;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register read, bypass selection, load-use scoreboard and a one-entry output register.
// Build option FORWARDING_EN enables ex/mem bypass and load-only scoreboard tracking.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  tag          in_rs1,
  input  tag          in_rs2,
  input  tag          in_rd,
  input  logic        in_uses_rs1,
  input  logic        in_uses_rs2,
  input  logic        in_writes_rd,
  input  logic        in_is_load,
  input  word         in_imm,
  output tag          rf_rs1,
  output tag          rf_rs2,
  input  word         rf_rs1_value,
  input  word         rf_rs2_value,
  input  logic        ex_fwd_valid,
  input  tag          ex_fwd_rd,
  input  word         ex_fwd_value,
  input  logic        mem_fwd_valid,
  input  tag          mem_fwd_rd,
  input  word         mem_fwd_value,
  input  logic        wb_valid,
  input  tag          wb_rd,
  input  word         wb_value,
  input  logic        wb_is_load,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output word         out_rs1_value,
  output word         out_rs2_value,
  output word         out_imm,
  output tag          out_rd,
  output logic        out_writes_rd,
  output logic        out_is_load,
  output logic [31:0] pending
);

  // Handshakes: a transfer happens on a clock edge where valid & ready are both high;
  // valid never depends on ready, and the output register holds while out_valid & !out_ready.

  logic [num_regs-1:0] pending_q, pending_d, set_mask, clr_mask;
  logic ex_v, mem_v, wb_clears, out_tracked, set_on_retire, waw;
  logic busy_rs1, busy_rs2, stall, accept, handshake;
  word  rs1_value, rs2_value;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

`ifdef FORWARDING_EN
  assign ex_v          = ex_fwd_valid;
  assign mem_v         = mem_fwd_valid;
  assign wb_clears     = wb_valid & wb_is_load;
  assign out_tracked   = out_valid & out_is_load;
  assign set_on_retire = out_is_load & out_writes_rd;
  assign waw           = 1'b0;
`else
  // Without ex/mem bypass every writer is tracked until write-back.
  logic unused_fwd;
  assign unused_fwd    = ^{ex_fwd_valid, mem_fwd_valid, wb_is_load};
  assign ex_v          = 1'b0;
  assign mem_v         = 1'b0;
  assign wb_clears     = wb_valid;
  assign out_tracked   = out_valid & out_writes_rd;
  assign set_on_retire = out_writes_rd;
  assign waw           = in_writes_rd & (in_rd != '0) & pending_q[in_rd];
`endif

  operand_bypass u_bypass_rs1 (
    .src       (in_rs1),
    .rf_value  (rf_rs1_value),
    .ex_valid  (ex_v),
    .ex_rd     (ex_fwd_rd),
    .ex_value  (ex_fwd_value),
    .mem_valid (mem_v),
    .mem_rd    (mem_fwd_rd),
    .mem_value (mem_fwd_value),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_value  (wb_value),
    .value     (rs1_value)
  );

  operand_bypass u_bypass_rs2 (
    .src       (in_rs2),
    .rf_value  (rf_rs2_value),
    .ex_valid  (ex_v),
    .ex_rd     (ex_fwd_rd),
    .ex_value  (ex_fwd_value),
    .mem_valid (mem_v),
    .mem_rd    (mem_fwd_rd),
    .mem_value (mem_fwd_value),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_value  (wb_value),
    .value     (rs2_value)
  );

  // A source is busy if its producer is still in flight: pending (unless written back now) or sitting in our output register.
  always_comb begin
    busy_rs1 = 1'b0;
    busy_rs2 = 1'b0;
    if (in_uses_rs1 && (in_rs1 != '0))
      busy_rs1 = (pending_q[in_rs1] && !(wb_clears && (wb_rd == in_rs1))) ||
                 (out_tracked && (out_rd == in_rs1));
    if (in_uses_rs2 && (in_rs2 != '0))
      busy_rs2 = (pending_q[in_rs2] && !(wb_clears && (wb_rd == in_rs2))) ||
                 (out_tracked && (out_rd == in_rs2));
  end

  assign stall     = busy_rs1 | busy_rs2 | waw;
  assign in_ready  = reset_n & ~stall & (~out_valid | out_ready) & ~flush;
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready & ~flush;

  // Set wins over a same-cycle clear of the same register.
  always_comb begin
    set_mask  = (handshake && set_on_retire) ? tag_mask(out_rd) : '0;
    clr_mask  = wb_clears ? tag_mask(wb_rd) : '0;
    pending_d = ((pending_q & ~clr_mask) | set_mask) & ~num_regs'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      pending_q <= '0;
    else
      pending_q <= pending_d;
  end

  assign pending = pending_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      out_rs1_value <= '0;
      out_rs2_value <= '0;
      out_imm       <= '0;
      out_rd        <= '0;
      out_writes_rd <= 1'b0;
      out_is_load   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_rs1_value <= rs1_value;
      out_rs2_value <= rs2_value;
      out_imm       <= in_imm;
      out_rd        <= in_rd;
      out_writes_rd <= in_writes_rd;
      out_is_load   <= in_is_load;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
